// File: rtl/inst_encoder.sv
// inst_encoder: pipelined RV32I instruction encoder.
//
// Takes a mnemonic code plus register and immediate fields over a
// valid/ready handshake. It returns the packed 32-bit instruction word two
// cycles later.
//   Stage 1 registers the request fields together with a legality flag.
//   Stage 2 packs those fields into the instruction format and registers the
//   result into the output slot, which supports backpressure.
// An illegal request comes out as NOP_WORD with out_err set.
//
// Ports
//   cpu_clk, cpu_rst_n   clock (rising edge), asynchronous active-low reset
//   flush                synchronous; drops both in-flight entries
//   in_valid/in_ready    request handshake
//   in_mnem              mnemonic code (0..23 legal, 24..31 illegal)
//   in_rd/in_rs1/in_rs2  register fields
//   in_imm               two's-complement immediate (byte offset for B/J,
//                        full 32-bit value for lui)
//   out_valid/out_ready  result handshake
//   out_inst, out_err    encoded word and illegal-request flag
//   inst_cnt             output handshakes, wraps
//   err_cnt              output handshakes with out_err, saturates
module inst_encoder #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned ERR_CNT_W = 16,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_mnem,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_inst,
  output logic                 out_err,
  output logic [CNT_W-1:0]     inst_cnt,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [4:0] {
    M_ADD  = 5'd0,  M_SUB  = 5'd1,  M_AND  = 5'd2,  M_OR   = 5'd3,
    M_XOR  = 5'd4,  M_SLL  = 5'd5,  M_SRL  = 5'd6,  M_SRA  = 5'd7,
    M_ADDI = 5'd8,  M_ANDI = 5'd9,  M_ORI  = 5'd10, M_XORI = 5'd11,
    M_SLLI = 5'd12, M_SRLI = 5'd13, M_SRAI = 5'd14, M_LW   = 5'd15,
    M_SW   = 5'd16, M_BEQ  = 5'd17, M_BNE  = 5'd18, M_BLT  = 5'd19,
    M_BGE  = 5'd20, M_LUI  = 5'd21, M_JAL  = 5'd22, M_JALR = 5'd23
  } mnem_e;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // ---------------------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------------------
  logic s1_valid;
  logic out_adv;
  logic s1_adv;
  logic in_fire;
  logic out_fire;

  // The output slot can take a new entry when it is empty or is being drained.
  assign out_adv  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && out_adv;
  // in_ready depends only on registered state, out_ready and flush.
  // It never depends on in_valid.
  assign in_ready = !flush && (!s1_valid || out_adv);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Stage 1: legality check on the incoming request
  // ---------------------------------------------------------------------------
  logic signed [31:0] imm_s;
  logic               fits_i12;
  logic               fits_shamt;
  logic               fits_b13;
  logic               fits_j21;
  logic               lui_ok;
  logic               req_err;

  assign imm_s      = in_imm;
  assign fits_i12   = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
  assign fits_shamt = (in_imm[31:5] == 27'd0);
  // Branch and jump offsets must be even; bit 0 is not encoded.
  assign fits_b13   = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !in_imm[0];
  assign fits_j21   = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !in_imm[0];
  assign lui_ok     = (in_imm[11:0] == 12'd0);

  always_comb begin
    req_err = 1'b1;
    case (in_mnem) inside
      [M_ADD:M_SRA]:                     req_err = 1'b0;
      [M_ADDI:M_XORI], M_LW, M_SW, M_JALR: req_err = !fits_i12;
      [M_SLLI:M_SRAI]:                   req_err = !fits_shamt;
      [M_BEQ:M_BGE]:                     req_err = !fits_b13;
      M_LUI:                             req_err = !lui_ok;
      M_JAL:                             req_err = !fits_j21;
      default:                           req_err = 1'b1;
    endcase
  end

  logic [4:0]  s1_mnem;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [31:0] s1_imm;
  logic        s1_err;

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      s1_valid <= 1'b0;
      s1_mnem  <= 5'd0;
      s1_rd    <= 5'd0;
      s1_rs1   <= 5'd0;
      s1_rs2   <= 5'd0;
      s1_imm   <= 32'd0;
      s1_err   <= 1'b0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (in_fire) begin
        s1_valid <= 1'b1;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      // in_fire is never true during a flush, because in_ready is held low.
      if (in_fire) begin
        s1_mnem <= in_mnem;
        s1_rd   <= in_rd;
        s1_rs1  <= in_rs1;
        s1_rs2  <= in_rs2;
        s1_imm  <= in_imm;
        s1_err  <= req_err;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: format packing. Fields a format does not use are left at zero.
  // ---------------------------------------------------------------------------
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] pack_word;

  always_comb begin
    funct3 = 3'b000;
    case (s1_mnem) inside
      M_AND, M_ANDI:                 funct3 = 3'b111;
      M_OR, M_ORI:                   funct3 = 3'b110;
      M_XOR, M_XORI, M_BLT:          funct3 = 3'b100;
      M_SLL, M_SLLI, M_BNE:          funct3 = 3'b001;
      M_SRL, M_SRA, M_SRLI, M_SRAI,
      M_BGE:                         funct3 = 3'b101;
      M_LW, M_SW:                    funct3 = 3'b010;
      default:                       funct3 = 3'b000;
    endcase

    funct7 = ((s1_mnem == M_SUB) || (s1_mnem == M_SRA) || (s1_mnem == M_SRAI))
             ? 7'b0100000 : 7'b0000000;

    pack_word = NOP_WORD;
    case (s1_mnem) inside
      [M_ADD:M_SRA]:
        pack_word = {funct7, s1_rs2, s1_rs1, funct3, s1_rd, OP_REG};
      [M_ADDI:M_XORI]:
        pack_word = {s1_imm[11:0], s1_rs1, funct3, s1_rd, OP_IMM};
      [M_SLLI:M_SRAI]:
        pack_word = {funct7, s1_imm[4:0], s1_rs1, funct3, s1_rd, OP_IMM};
      M_LW:
        pack_word = {s1_imm[11:0], s1_rs1, funct3, s1_rd, OP_LOAD};
      M_SW:
        pack_word = {s1_imm[11:5], s1_rs2, s1_rs1, funct3, s1_imm[4:0], OP_STORE};
      [M_BEQ:M_BGE]:
        pack_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, funct3,
                     s1_imm[4:1], s1_imm[11], OP_BRANCH};
      M_LUI:
        pack_word = {s1_imm[31:12], s1_rd, OP_LUI};
      M_JAL:
        pack_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                     s1_rd, OP_JAL};
      M_JALR:
        pack_word = {s1_imm[11:0], s1_rs1, funct3, s1_rd, OP_JALR};
      default:
        pack_word = NOP_WORD;
    endcase

    if (s1_err) begin
      pack_word = NOP_WORD;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register. Its contents hold while out_valid && !out_ready.
  // ---------------------------------------------------------------------------
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      out_valid <= 1'b0;
      out_inst  <= 32'd0;
      out_err   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (out_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_inst <= pack_word;
        out_err  <= s1_err;
      end
    end
  end

  // Counters see every output handshake, including one that happens in the
  // same cycle as a flush.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      inst_cnt <= '0;
      err_cnt  <= '0;
    end else if (out_fire) begin
      inst_cnt <= inst_cnt + CNT_W'(1);
      if (out_err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Testbench for inst_encoder.
//
// The reference model builds each expected word from the RV32I field layout
// using plain integer arithmetic. Requests are recorded when they are
// accepted. Results are paired with their expected values when they are
// handed off. Each test task then compares its own results.
// The error counter is narrowed to 5 bits so that saturation is reached
// quickly.
module tb_inst_encoder;

  localparam int EW = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  mnem = 5'd0;
  logic [4:0]  rd = 5'd0;
  logic [4:0]  rs1 = 5'd0;
  logic [4:0]  rs2 = 5'd0;
  logic [31:0] imm = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic        out_err;
  logic [31:0] inst_cnt;
  logic [EW-1:0] err_cnt;

  inst_encoder #(.CNT_W(32), .ERR_CNT_W(EW), .NOP_WORD(32'h0000_0013)) dut (
    .cpu_clk   (clk),
    .cpu_rst_n (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mnem   (mnem),
    .in_rd     (rd),
    .in_rs1    (rs1),
    .in_rs2    (rs2),
    .in_imm    (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .inst_cnt  (inst_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [32:0] exp_q[$];   // accepted, not yet delivered: {err, word}
  logic [32:0] act_q[$];   // delivered by the DUT
  logic [32:0] expd_q[$];  // expected values paired with act_q
  int          cyc_q[$];   // cycle in which each delivery happened
  int          cycle = 0;
  int          spurious = 0;
  int          last_in_cyc = 0;
  bit          last_in_fire = 1'b0;
  logic [31:0] m_inst = 32'd0;
  int          m_err = 0;

  int edge_vals [20] = '{-2049, -2048, 2047, 2048, -1, 0, 31, 32, -4096, -4097,
                         4094, 4095, 4096, -1048576, -1048578, 1048574,
                         1048575, 1048576, 32'h12345000, -4095};

  typedef enum {F_R, F_I, F_SH, F_S, F_B, F_U, F_J, F_BAD} fmt_t;

  // Reference encoder: returns {err, word}.
  function automatic logic [32:0] model_encode(input logic [4:0] m, input logic [4:0] r_d,
                                               input logic [4:0] r_s1, input logic [4:0] r_s2,
                                               input logic [31:0] im);
    fmt_t        fmt;
    logic [31:0] op;
    logic [31:0] f3;
    logic [31:0] hi;
    logic [31:0] w;
    longint      v;
    bit          ok;
    v  = longint'($signed(im));
    hi = 32'd0;
    f3 = 32'd0;
    op = 32'h13;
    case (m)
      5'd0: begin fmt = F_R; op = 32'h33; f3 = 0; end
      5'd1: begin fmt = F_R; op = 32'h33; f3 = 0; hi = 32'h4000_0000; end
      5'd2: begin fmt = F_R; op = 32'h33; f3 = 7; end
      5'd3: begin fmt = F_R; op = 32'h33; f3 = 6; end
      5'd4: begin fmt = F_R; op = 32'h33; f3 = 4; end
      5'd5: begin fmt = F_R; op = 32'h33; f3 = 1; end
      5'd6: begin fmt = F_R; op = 32'h33; f3 = 5; end
      5'd7: begin fmt = F_R; op = 32'h33; f3 = 5; hi = 32'h4000_0000; end
      5'd8: begin fmt = F_I; f3 = 0; end
      5'd9: begin fmt = F_I; f3 = 7; end
      5'd10: begin fmt = F_I; f3 = 6; end
      5'd11: begin fmt = F_I; f3 = 4; end
      5'd12: begin fmt = F_SH; f3 = 1; end
      5'd13: begin fmt = F_SH; f3 = 5; end
      5'd14: begin fmt = F_SH; f3 = 5; hi = 32'h4000_0000; end
      5'd15: begin fmt = F_I; op = 32'h03; f3 = 2; end
      5'd16: begin fmt = F_S; op = 32'h23; f3 = 2; end
      5'd17: begin fmt = F_B; op = 32'h63; f3 = 0; end
      5'd18: begin fmt = F_B; op = 32'h63; f3 = 1; end
      5'd19: begin fmt = F_B; op = 32'h63; f3 = 4; end
      5'd20: begin fmt = F_B; op = 32'h63; f3 = 5; end
      5'd21: begin fmt = F_U; op = 32'h37; end
      5'd22: begin fmt = F_J; op = 32'h6F; end
      5'd23: begin fmt = F_I; op = 32'h67; f3 = 0; end
      default: fmt = F_BAD;
    endcase
    w  = 32'd0;
    ok = 1'b1;
    case (fmt)
      F_R: w = op | (32'(r_d) << 7) | (f3 << 12) | (32'(r_s1) << 15) | (32'(r_s2) << 20) | hi;
      F_I: begin
        ok = (v >= -2048) && (v <= 2047);
        w  = op | (32'(r_d) << 7) | (f3 << 12) | (32'(r_s1) << 15) | ((im & 32'hFFF) << 20);
      end
      F_SH: begin
        ok = (v >= 0) && (v <= 31);
        w  = op | (32'(r_d) << 7) | (f3 << 12) | (32'(r_s1) << 15) | (im << 20) | hi;
      end
      F_S: begin
        ok = (v >= -2048) && (v <= 2047);
        w  = op | ((im & 31) << 7) | (f3 << 12) | (32'(r_s1) << 15) | (32'(r_s2) << 20)
             | (((im >> 5) & 127) << 25);
      end
      F_B: begin
        ok = (v >= -4096) && (v <= 4094) && ((im & 1) == 0);
        w  = op | (((im >> 11) & 1) << 7) | (((im >> 1) & 15) << 8) | (f3 << 12)
             | (32'(r_s1) << 15) | (32'(r_s2) << 20) | (((im >> 5) & 63) << 25)
             | (((im >> 12) & 1) << 31);
      end
      F_U: begin
        ok = ((im & 32'hFFF) == 0);
        w  = op | (32'(r_d) << 7) | (im & 32'hFFFF_F000);
      end
      F_J: begin
        ok = (v >= -1048576) && (v <= 1048574) && ((im & 1) == 0);
        w  = op | (32'(r_d) << 7) | (((im >> 12) & 255) << 12) | (((im >> 11) & 1) << 20)
             | (((im >> 1) & 1023) << 21) | (((im >> 20) & 1) << 31);
      end
      default: ok = 1'b0;
    endcase
    if (!ok) return {1'b1, 32'h0000_0013};
    return {1'b0, w};
  endfunction

  // One clock: sample the handshakes just after the negedge, update the
  // model, then wait for the next negedge.
  task automatic tick();
    logic [32:0] e;
    #1;
    last_in_fire = in_valid && in_ready;
    if (out_valid && out_ready) begin
      m_inst = m_inst + 32'd1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act_q.push_back({out_err, out_inst});
        expd_q.push_back(e);
        cyc_q.push_back(cycle);
        if (e[32] && m_err < (2**EW - 1)) m_err++;
      end else begin
        spurious++;
      end
    end
    if (last_in_fire) begin
      exp_q.push_back(model_encode(mnem, rd, rs1, rs2, imm));
      last_in_cyc = cycle;
    end
    if (flush) exp_q.delete();
    cycle++;
    @(negedge clk);
  endtask

  task automatic send(input logic [4:0] m, input logic [4:0] r_d, input logic [4:0] r_s1,
                      input logic [4:0] r_s2, input logic [31:0] im);
    mnem = m; rd = r_d; rs1 = r_s1; rs2 = r_s2; imm = im;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (last_in_fire) break;
    end
    if (!last_in_fire) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: mnem=%0d not accepted, want accept within 50 cycles", m);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d words outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic new_req();
    mnem = 5'($urandom_range(0, 27));
    rd   = 5'($urandom);
    rs1  = 5'($urandom);
    rs2  = 5'($urandom);
    case ($urandom_range(0, 4))
      0: imm = 32'($urandom_range(0, 63)) - 32'd32;
      1: imm = 32'(edge_vals[$urandom_range(0, 19)]);
      2: imm = $urandom;
      3: imm = $urandom & 32'hFFFF_F000;
      default: imm = ($urandom & 32'h1) != 0 ? -(32'($urandom_range(0, 2047)) << 1)
                                              : (32'($urandom_range(0, 2047)) << 1);
    endcase
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_inst !== 32'd0) begin n_bad++; $display("FAIL reset_out_inst: got %08h want 00000000", out_inst); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err: got %b want 0", out_err); end
    n_cmp++; if (inst_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_inst_cnt: got %0d want 0", inst_cnt); end
    n_cmp++; if (err_cnt !== '0) begin n_bad++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_add();
    logic [32:0] a;
    int          acc_cyc;
    cyc_q.delete();
    out_ready = 1'b1;
    send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    acc_cyc = last_in_cyc;
    drain();
    n_cmp++;
    if (act_q.size() != 1) begin
      n_bad++; $display("FAIL add_count: got %0d words want 1", act_q.size());
    end else begin
      a = act_q.pop_front(); void'(expd_q.pop_front());
      n_cmp++; if (a !== {1'b0, 32'h002081B3}) begin n_bad++; $display("FAIL add_word: got err=%b inst=%08h want err=0 inst=002081b3", a[32], a[31:0]); end
      n_cmp++; if (cyc_q[0] != acc_cyc + 2) begin n_bad++; $display("FAIL add_latency: got %0d cycles want 2", cyc_q[0] - acc_cyc); end
    end
    n_cmp++; if (inst_cnt !== 32'd1) begin n_bad++; $display("FAIL add_inst_cnt: got %0d want 1", inst_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [32:0] want [7];
    logic [32:0] a;
    logic [32:0] e;
    want[0] = {1'b0, 32'hFFF00093}; want[1] = {1'b0, 32'h4030D093};
    want[2] = {1'b0, 32'h0020A423}; want[3] = {1'b0, 32'h123452B7};
    want[4] = {1'b0, 32'hFE208EE3}; want[5] = {1'b0, 32'h008000EF};
    want[6] = {1'b1, 32'h00000013};
    cyc_q.delete();
    out_ready = 1'b1;
    send(5'd8,  5'd1, 5'd0, 5'd7, 32'hFFFF_FFFF);   // addi x1,x0,-1
    send(5'd14, 5'd1, 5'd1, 5'd9, 32'd3);           // srai x1,x1,3
    send(5'd16, 5'd9, 5'd1, 5'd2, 32'd8);           // sw x2,8(x1)
    send(5'd21, 5'd5, 5'd4, 5'd6, 32'h1234_5000);   // lui x5,0x12345
    send(5'd17, 5'd7, 5'd1, 5'd2, 32'hFFFF_FFFC);   // beq x1,x2,-4
    send(5'd22, 5'd1, 5'd3, 5'd6, 32'd8);           // jal x1,8
    send(5'd17, 5'd0, 5'd1, 5'd2, 32'd3);           // beq odd offset
    drain();
    n_cmp++;
    if (act_q.size() != 7) begin
      n_bad++; $display("FAIL b2b_count: got %0d words want 7", act_q.size());
    end
    for (int i = 0; i < 7 && act_q.size() > 0; i++) begin
      a = act_q.pop_front(); e = expd_q.pop_front();
      n_cmp++; if (a !== want[i]) begin n_bad++; $display("FAIL b2b_word%0d: got err=%b inst=%08h want err=%b inst=%08h", i, a[32], a[31:0], want[i][32], want[i][31:0]); end
      n_cmp++; if (e !== want[i]) begin n_bad++; $display("FAIL b2b_model%0d: model gives %09h want %09h", i, e, want[i]); end
    end
    for (int i = 1; i < cyc_q.size(); i++) begin
      n_cmp++; if (cyc_q[i] != cyc_q[i-1] + 1) begin n_bad++; $display("FAIL b2b_throughput: word %0d gap %0d cycles want 1", i, cyc_q[i] - cyc_q[i-1]); end
    end
    n_cmp++; if (err_cnt !== 5'd1) begin n_bad++; $display("FAIL b2b_err_cnt: got %0d want 1", err_cnt); end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    bit          have;
    logic [32:0] a;
    logic [32:0] e;
    have = 1'b0;
    held = 32'd0;
    out_ready = 1'b0;
    new_req();
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (last_in_fire) new_req();
      #1;
      if (out_valid) begin
        if (!have) begin
          held = out_inst; have = 1'b1;
        end else begin
          n_cmp++; if (out_inst !== held) begin n_bad++; $display("FAIL bp_stable: got %08h want %08h", out_inst, held); end
        end
      end
    end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
    drain();
    n_cmp++; if (act_q.size() != 2) begin n_bad++; $display("FAIL bp_count: got %0d words want 2", act_q.size()); end
    while (act_q.size() > 0) begin
      a = act_q.pop_front(); e = expd_q.pop_front();
      n_cmp++; if (a !== e) begin n_bad++; $display("FAIL bp_word: got err=%b inst=%08h want err=%b inst=%08h", a[32], a[31:0], e[32], e[31:0]); end
    end
  endtask

  task automatic test_illegal();
    logic [32:0] a;
    out_ready = 1'b1;
    send(5'd27, 5'd1, 5'd2, 5'd3, 32'd0);
    send(5'd8, 5'd1, 5'd2, 5'd3, 32'd2048);
    drain();
    n_cmp++; if (act_q.size() != 2) begin n_bad++; $display("FAIL ill_count: got %0d words want 2", act_q.size()); end
    while (act_q.size() > 0) begin
      a = act_q.pop_front(); void'(expd_q.pop_front());
      n_cmp++; if (a !== {1'b1, 32'h00000013}) begin n_bad++; $display("FAIL ill_word: got err=%b inst=%08h want err=1 inst=00000013", a[32], a[31:0]); end
    end
    for (int k = 0; k < 40; k++) send(5'($urandom_range(24, 31)), 5'd1, 5'd1, 5'd1, $urandom);
    drain();
    act_q.delete(); expd_q.delete();
    n_cmp++; if (err_cnt !== 5'h1F) begin n_bad++; $display("FAIL sat_err_cnt: got %0d want 31", err_cnt); end
    n_cmp++; if (inst_cnt !== m_inst) begin n_bad++; $display("FAIL sat_inst_cnt: got %0d want %0d", inst_cnt, m_inst); end
  endtask

  task automatic test_random();
    logic [32:0] a;
    logic [32:0] e;
    in_valid = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!in_valid && ($urandom_range(0, 3) != 0)) begin
        new_req();
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (last_in_fire) in_valid = 1'b0;
    end
    drain();
    while (act_q.size() > 0) begin
      a = act_q.pop_front(); e = expd_q.pop_front();
      n_cmp++; if (a !== e) begin n_bad++; $display("FAIL rand_word: got err=%b inst=%08h want err=%b inst=%08h", a[32], a[31:0], e[32], e[31:0]); end
    end
    n_cmp++; if (spurious != 0) begin n_bad++; $display("FAIL rand_spurious: got %0d extra words want 0", spurious); end
    n_cmp++; if (inst_cnt !== m_inst) begin n_bad++; $display("FAIL rand_inst_cnt: got %0d want %0d", inst_cnt, m_inst); end
    n_cmp++; if (err_cnt !== EW'(m_err)) begin n_bad++; $display("FAIL rand_err_cnt: got %0d want %0d", err_cnt, m_err); end
  endtask

  task automatic test_flush();
    logic [32:0] a;
    logic [32:0] e;
    // Flush with both stages full and the output stalled.
    out_ready = 1'b0;
    send(5'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    send(5'd2, 5'd4, 5'd5, 5'd6, 32'd0);
    flush = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    tick();
    flush = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    out_ready = 1'b1;
    repeat (3) tick();
    n_cmp++; if (act_q.size() != 0 || spurious != 0) begin n_bad++; $display("FAIL flush_leak: got %0d words want 0", act_q.size() + spurious); end
    // A handshake in the flush cycle is still delivered and counted.
    out_ready = 1'b0;
    send(5'd3, 5'd1, 5'd2, 5'd3, 32'd0);
    send(5'd4, 5'd4, 5'd5, 5'd6, 32'd0);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush2_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (inst_cnt !== m_inst) begin n_bad++; $display("FAIL flush2_inst_cnt: got %0d want %0d", inst_cnt, m_inst); end
    n_cmp++; if (act_q.size() != 1) begin n_bad++; $display("FAIL flush2_count: got %0d words want 1", act_q.size()); end
    while (act_q.size() > 0) begin
      a = act_q.pop_front(); e = expd_q.pop_front();
      n_cmp++; if (a !== e) begin n_bad++; $display("FAIL flush2_word: got err=%b inst=%08h want err=%b inst=%08h", a[32], a[31:0], e[32], e[31:0]); end
    end
  endtask

  task automatic test_async_reset();
    logic [32:0] a;
    logic [32:0] e;
    out_ready = 1'b0;
    send(5'd5, 5'd1, 5'd2, 5'd3, 32'd0);
    send(5'd6, 5'd4, 5'd5, 5'd6, 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (inst_cnt !== 32'd0) begin n_bad++; $display("FAIL arst_inst_cnt: got %0d want 0", inst_cnt); end
    n_cmp++; if (err_cnt !== '0) begin n_bad++; $display("FAIL arst_err_cnt: got %0d want 0", err_cnt); end
    exp_q.delete(); act_q.delete(); expd_q.delete();
    m_inst = 32'd0; m_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL arst_in_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    send(5'd1, 5'd3, 5'd1, 5'd2, 32'd0);
    drain();
    n_cmp++; if (act_q.size() != 1) begin n_bad++; $display("FAIL arst_count: got %0d words want 1", act_q.size()); end
    while (act_q.size() > 0) begin
      a = act_q.pop_front(); e = expd_q.pop_front();
      n_cmp++; if (a !== e) begin n_bad++; $display("FAIL arst_word: got err=%b inst=%08h want err=%b inst=%08h", a[32], a[31:0], e[32], e[31:0]); end
    end
    n_cmp++; if (inst_cnt !== 32'd1) begin n_bad++; $display("FAIL arst_inst_cnt_after: got %0d want 1", inst_cnt); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_random();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Pipelined RV32I instruction encoder: accepts mnemonic + register + immediate fields over valid/ready and emits the packed 32-bit instruction word.
- Inverse of the pipeline's instruction decoder. Supports exactly the instruction subset that decoder recognises.
- Used by the trace/self-test harness to build instruction streams for IROM preload and to cross-check against decode.
- Two-stage pipeline: field/range check, then format packing, then a registered output with backpressure.

Parameters:
- CNT_W, 32, width of emitted-instruction counter.
- ERR_CNT_W, 16, width of saturating error counter.
- NOP_WORD, 32'h00000013, word emitted in place of an illegal request.

Ports:
- cpu_clk  in  1  clock, rising edge.
- cpu_rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; drops all in-flight entries.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_mnem  in  5  mnemonic code, see Behaviour.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_imm  in  32  two's-complement immediate. Byte offset for B/J; full value for LUI.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer ready.
- out_inst  out  32  encoded instruction.
- out_err  out  1  request was illegal; out_inst = NOP_WORD.
- inst_cnt  out  CNT_W  count of output handshakes, wraps.
- err_cnt  out  ERR_CNT_W  count of out_err handshakes, saturates at all-ones.

Behaviour:
- Mnemonic codes:
  - R-type: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra.
  - I-type ALU: 8 addi, 9 andi, 10 ori, 11 xori, 12 slli, 13 srli, 14 srai.
  - Other: 15 lw, 16 sw, 17 beq, 18 bne, 19 blt, 20 bge, 21 lui, 22 jal, 23 jalr.
  - 24–31 are illegal.
- Field encoding: standard RV32I opcode/funct3/funct7. funct7 is 0100000 for sub, sra, srai, else 0. Fields not used by a format are forced to 0 (e.g. rd for sw/branches, rs2 for I-type, rs1 for lui/jal).
- Legality, evaluated in stage 1:
  - I-type/lw/jalr/sw: imm in [-2048, 2047].
  - Shifts: imm in [0, 31].
  - Branches: imm in [-4096, 4094] and imm[0] = 0.
  - jal: imm in [-1048576, 1048574] and imm[0] = 0.
  - lui: imm[11:0] = 0.
  - Any violation or illegal code sets err. err takes priority; out_inst = NOP_WORD.
- Pipeline: stage-1 register (fields + err) → stage-2/output register (out_inst, out_err, out_valid).
  - Latency: request accepted in cycle N appears on out_* in cycle N+2 when out_ready has been held high.
  - Throughput: one instruction per cycle.
- Flow control:
  - Output advances when !out_valid || out_ready.
  - Stage 1 advances into output when it is valid and output advances.
  - in_ready = !s1_valid || (output advances). Combinational; no combinational path from in_valid to in_ready.
  - out_* hold stable while out_valid && !out_ready.
- Counters:
  - inst_cnt increments on out_valid && out_ready and wraps to 0.
  - err_cnt increments on the same handshake when out_err = 1 and saturates.
- flush: clears s1_valid and out_valid next edge; in_ready = 0 during the flush cycle; counters unchanged. A handshake coincident with flush is still counted.
- Reset (async, cpu_rst_n = 0): s1_valid = 0, out_valid = 0, out_inst = 0, out_err = 0, inst_cnt = 0, err_cnt = 0. After release, in_ready = 1. Mid-stream reset discards all in-flight entries.

Test Plan:
- add x3,x1,x2 (mnem 0, rd 3, rs1 1, rs2 2), out_ready = 1 → out_inst = 0x002081B3 two cycles after accept, out_err = 0, inst_cnt = 1.
- Back-to-back stream:
  - addi x1,x0,-1 → 0xFFF00093.
  - srai x1,x1,3 → 0x4030D093.
  - sw x2,8(x1) → 0x0020A423.
  - lui x5,0x12345000 → 0x123452B7.
  - Required: one output per cycle, in order.
- beq x1,x2,-4 → 0xFE208EE3; jal x1,8 → 0x008000EF. Then beq imm = 3 (odd) → out_inst = 0x00000013, out_err = 1, err_cnt = 1.
- Backpressure: hold out_ready = 0 for 5 cycles with in_valid = 1 → out_inst stable, in_ready = 0 once both stages are full, no word lost or duplicated after release.
- Illegal mnem 27 and addi imm = 2048 → both NOP_WORD with out_err = 1. With err_cnt preset near max, err_cnt saturates at 0xFFFF.
- Assert cpu_rst_n = 0 asynchronously with both stages valid → out_valid drops immediately, counters = 0. flush with stages full → no output next cycle.
